// File: rtl/mem_io_bridge.sv
// Address decoder and I/O block between the CPU memory port and the 8Kx16 block RAM.
// The top words of the address space map to an LED register, synchronised switches and a reload timer.
module mem_io_bridge #(
  parameter logic [12:0] IO_BASE = 13'h1FF0,
  parameter int unsigned SW_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrEn,
  input  logic [12:0]     addr_toRAM,
  input  logic [15:0]     data_toRAM,
  output logic [15:0]     data_fromRAM,
  output logic [12:0]     ram_addr,
  output logic [15:0]     ram_wdata,
  output logic            ram_we,
  input  logic [15:0]     ram_rdata,
  input  logic [SW_W-1:0] sw_in,
  output logic [15:0]     led_out
);

  localparam logic [3:0] OFF_LED  = 4'd0;
  localparam logic [3:0] OFF_SW   = 4'd1;
  localparam logic [3:0] OFF_TCNT = 4'd2;
  localparam logic [3:0] OFF_TCTL = 4'd3;
  localparam logic [3:0] OFF_TRLD = 4'd4;

  logic            is_io;
  logic [12:0]     io_off;
  logic            in_window;
  logic [3:0]      reg_sel;
  logic            wr_io;
  logic            wr_led, wr_tcnt, wr_tctl, wr_trld;

  logic [15:0]     led_q, led_d;
  logic [15:0]     tcnt_q, tcnt_d;
  logic [15:0]     trld_q, trld_d;
  logic            en_q, en_d;
  logic            auto_q, auto_d;
  logic            ovf_q, ovf_d;
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;
  logic            sel_io_q;
  logic [15:0]     io_rdata_q, io_rdata_d;
  logic [15:0]     sw_rd;
  logic            tmr_wrap;

  assign is_io     = (addr_toRAM >= IO_BASE);
  assign io_off    = addr_toRAM - IO_BASE;
  assign in_window = is_io && (io_off[12:4] == 9'd0);
  assign reg_sel   = io_off[3:0];

  assign ram_addr  = addr_toRAM;
  assign ram_wdata = data_toRAM;
  assign ram_we    = wrEn & ~is_io;

  assign wr_io   = wrEn & in_window;
  assign wr_led  = wr_io && (reg_sel == OFF_LED);
  assign wr_tcnt = wr_io && (reg_sel == OFF_TCNT);
  assign wr_tctl = wr_io && (reg_sel == OFF_TCTL);
  assign wr_trld = wr_io && (reg_sel == OFF_TRLD);

  assign led_d  = wr_led  ? data_toRAM : led_q;
  assign trld_d = wr_trld ? data_toRAM : trld_q;

  always_comb begin
    sw_rd = '0;
    sw_rd[SW_W-1:0] = sw_sync_q;
  end

  // CPU writes are applied after the timer update so they override it; the overflow set is applied last so it beats a clear.
  always_comb begin
    tcnt_d   = tcnt_q;
    en_d     = en_q;
    auto_d   = auto_q;
    ovf_d    = ovf_q;
    tmr_wrap = 1'b0;
    if (en_q) begin
      if (tcnt_q == 16'hFFFF) begin
        tmr_wrap = 1'b1;
        if (auto_q) begin
          tcnt_d = trld_q;
        end else begin
          tcnt_d = 16'h0000;
          en_d   = 1'b0;
        end
      end else begin
        tcnt_d = tcnt_q + 16'd1;
      end
    end
    if (wr_tcnt) begin
      tcnt_d = data_toRAM;
    end
    if (wr_tctl) begin
      en_d   = data_toRAM[0];
      auto_d = data_toRAM[1];
      if (data_toRAM[15]) begin
        ovf_d = 1'b0;
      end
    end
    if (tmr_wrap) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    io_rdata_d = 16'h0000;
    if (in_window) begin
      case (reg_sel)
        OFF_LED:  io_rdata_d = led_q;
        OFF_SW:   io_rdata_d = sw_rd;
        OFF_TCNT: io_rdata_d = tcnt_q;
        OFF_TCTL: io_rdata_d = {ovf_q, 13'b0, auto_q, en_q};
        OFF_TRLD: io_rdata_d = trld_q;
        default:  io_rdata_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q      <= '0;
      tcnt_q     <= '0;
      trld_q     <= '0;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      ovf_q      <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      sel_io_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      led_q      <= led_d;
      tcnt_q     <= tcnt_d;
      trld_q     <= trld_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      ovf_q      <= ovf_d;
      sw_meta_q  <= sw_in;
      sw_sync_q  <= sw_meta_q;
      sel_io_q   <= is_io;
      io_rdata_q <= io_rdata_d;
    end
  end

  assign data_fromRAM = sel_io_q ? io_rdata_q : ram_rdata;
  assign led_out      = led_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed self-checking bench for mem_io_bridge: decode, read latency, LED, switches and timer corner cases.
module tb_mem_io_bridge;

  logic        clk;
  logic        rst;
  logic        wrEn;
  logic [12:0] addr_toRAM;
  logic [15:0] data_toRAM;
  logic [15:0] data_fromRAM;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [7:0]  sw_in;
  logic [15:0] led_out;

  int testsRun    = 0;
  int testsFailed = 0;

  mem_io_bridge #(.IO_BASE(13'h1FF0), .SW_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .wrEn         (wrEn),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM),
    .data_fromRAM (data_fromRAM),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata),
    .sw_in        (sw_in),
    .led_out      (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [12:0] a, input logic [15:0] d);
    wrEn       = we;
    addr_toRAM = a;
    data_toRAM = d;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst        = 1'b0;
    ram_rdata  = 16'hABCD;
    sw_in      = 8'h00;
    applyStimulus(1'b0, 13'h0000, 16'h0000);
    #3;
    checkOutput("reset_led", led_out, 16'h0000);
    checkOutput("reset_rdata", data_fromRAM, 16'hABCD);
    checkOutput("reset_we", {15'b0, ram_we}, 16'h0000);
    #20;
    rst = 1'b1;

    applyStimulus(1'b0, 13'h1FF3, 16'h0000);
    tick();
    checkOutput("tctl_after_reset", data_fromRAM, 16'h0000);

    // LED write: same-cycle read returns the old value, the next read the new one
    applyStimulus(1'b1, 13'h1FF0, 16'h00A5);
    #1;
    checkOutput("led_write_no_ram_we", {15'b0, ram_we}, 16'h0000);
    tick();
    checkOutput("led_out_after_write", led_out, 16'h00A5);
    checkOutput("led_read_old_value", data_fromRAM, 16'h0000);
    applyStimulus(1'b0, 13'h1FF0, 16'h0000);
    tick();
    checkOutput("led_read_back", data_fromRAM, 16'h00A5);

    applyStimulus(1'b1, 13'h1FEF, 16'h5A5A);
    #1;
    checkOutput("ram_we_boundary", {15'b0, ram_we}, 16'h0001);
    checkOutput("ram_addr_pass", {3'b0, ram_addr}, 16'h1FEF);
    checkOutput("ram_wdata_pass", ram_wdata, 16'h5A5A);
    tick();
    checkOutput("led_unchanged_by_ram_write", led_out, 16'h00A5);

    // Back-to-back RAM / I/O / RAM reads across the boundary
    ram_rdata = 16'h1234;
    applyStimulus(1'b0, 13'h1FEF, 16'h0000);
    tick();
    checkOutput("ram_read_1FEF", data_fromRAM, 16'h1234);
    applyStimulus(1'b0, 13'h1FF0, 16'h0000);
    tick();
    checkOutput("io_read_1FF0", data_fromRAM, 16'h00A5);
    applyStimulus(1'b0, 13'h1FEF, 16'h0000);
    tick();
    checkOutput("ram_read_again", data_fromRAM, 16'h1234);

    // Auto-reload timer wrap
    applyStimulus(1'b1, 13'h1FF2, 16'hFFFE);
    tick();
    applyStimulus(1'b1, 13'h1FF4, 16'h1000);
    tick();
    applyStimulus(1'b1, 13'h1FF3, 16'h0003);
    tick();
    applyStimulus(1'b0, 13'h1FF2, 16'h0000);
    tick();
    checkOutput("tcnt_fffe", data_fromRAM, 16'hFFFE);
    tick();
    checkOutput("tcnt_ffff", data_fromRAM, 16'hFFFF);
    tick();
    checkOutput("tcnt_reload", data_fromRAM, 16'h1000);
    applyStimulus(1'b0, 13'h1FF3, 16'h0000);
    tick();
    checkOutput("tctl_ovf_set", data_fromRAM, 16'h8003);
    applyStimulus(1'b1, 13'h1FF3, 16'h8003);
    tick();
    applyStimulus(1'b0, 13'h1FF3, 16'h0000);
    tick();
    checkOutput("tctl_ovf_cleared", data_fromRAM, 16'h0003);
    applyStimulus(1'b0, 13'h1FF4, 16'h0000);
    tick();
    checkOutput("trld_read", data_fromRAM, 16'h1000);

    applyStimulus(1'b1, 13'h1FF2, 16'h0005);
    tick();
    applyStimulus(1'b0, 13'h1FF2, 16'h0000);
    tick();
    checkOutput("tcnt_write_wins", data_fromRAM, 16'h0005);
    tick();
    checkOutput("tcnt_counts_on", data_fromRAM, 16'h0006);

    // OVF clear on the wrap edge loses to the set
    applyStimulus(1'b1, 13'h1FF2, 16'hFFFE);
    tick();
    applyStimulus(1'b0, 13'h1FF2, 16'h0000);
    tick();
    applyStimulus(1'b1, 13'h1FF3, 16'h8003);
    tick();
    applyStimulus(1'b0, 13'h1FF3, 16'h0000);
    tick();
    checkOutput("ovf_set_beats_clear", data_fromRAM, 16'h8003);

    // One-shot stop
    applyStimulus(1'b1, 13'h1FF3, 16'h8000);
    tick();
    applyStimulus(1'b1, 13'h1FF2, 16'hFFFF);
    tick();
    applyStimulus(1'b1, 13'h1FF3, 16'h0001);
    tick();
    applyStimulus(1'b0, 13'h1FF3, 16'h0000);
    tick();
    checkOutput("oneshot_tctl_before", data_fromRAM, 16'h0001);
    tick();
    checkOutput("oneshot_tctl_after", data_fromRAM, 16'h8000);
    applyStimulus(1'b0, 13'h1FF2, 16'h0000);
    tick();
    checkOutput("oneshot_tcnt_zero", data_fromRAM, 16'h0000);
    tick();
    checkOutput("oneshot_stays_stopped", data_fromRAM, 16'h0000);

    // One-shot wrap with a simultaneous EN=1 write keeps running
    applyStimulus(1'b1, 13'h1FF3, 16'h8000);
    tick();
    applyStimulus(1'b1, 13'h1FF2, 16'hFFFF);
    tick();
    applyStimulus(1'b1, 13'h1FF3, 16'h0001);
    tick();
    applyStimulus(1'b1, 13'h1FF3, 16'h0001);
    tick();
    applyStimulus(1'b0, 13'h1FF3, 16'h0000);
    tick();
    checkOutput("oneshot_en_write_wins", data_fromRAM, 16'h8001);
    applyStimulus(1'b0, 13'h1FF2, 16'h0000);
    tick();
    checkOutput("oneshot_rerun_count", data_fromRAM, 16'h0001);

    // Switch synchroniser latency
    sw_in = 8'h3C;
    applyStimulus(1'b0, 13'h1FF1, 16'h0000);
    tick();
    checkOutput("sw_edge1", data_fromRAM, 16'h0000);
    tick();
    checkOutput("sw_edge2", data_fromRAM, 16'h0000);
    tick();
    checkOutput("sw_edge3", data_fromRAM, 16'h003C);

    applyStimulus(1'b1, 13'h1FF7, 16'hBEEF);
    #1;
    checkOutput("unmapped_no_ram_we", {15'b0, ram_we}, 16'h0000);
    tick();
    applyStimulus(1'b0, 13'h1FF7, 16'h0000);
    tick();
    checkOutput("unmapped_read_zero", data_fromRAM, 16'h0000);
    checkOutput("unmapped_write_ignored", led_out, 16'h00A5);

    // Asynchronous reset mid-count
    applyStimulus(1'b0, 13'h1FF2, 16'h0000);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_led", led_out, 16'h0000);
    checkOutput("async_reset_rdata", data_fromRAM, 16'h1234);
    tick();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("post_reset_tcnt", data_fromRAM, 16'h0000);
    applyStimulus(1'b0, 13'h1FF3, 16'h0000);
    tick();
    checkOutput("post_reset_tctl", data_fromRAM, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
